// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD conversion/arithmetic family:
//   - state_t       : FSM state encoding used by bcd_to_bin
//   - DIGIT_MAX     : largest legal BCD digit value
//   - ADJ_THRESH    : digit value at or above which a correction is applied
//   - ADJ_OFFSET    : correction amount subtracted after a right shift
//   - digit_invalid : flags a 4-bit nibble that is not a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;

  // A nibble above 9 cannot appear in a well-formed BCD operand.
  function automatic logic digit_invalid(input logic [3:0] digit);
    return (digit > DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Per-digit correction step of the reverse double-dabble conversion. After a
// right shift, a bit leaving the next-higher digit lands in this digit's MSB
// carrying weight 8, while its true decimal weight is 5; subtracting 3 from
// any digit that reached 8 or more restores the correct decimal value.
// Ports:
//   i_digit : 4-bit digit after the shift
//   o_digit : corrected 4-bit digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // Conditional subtract-3 correction.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADJ_THRESH) begin
      o_digit = i_digit - ADJ_OFFSET;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
// Sequential packed-BCD to unsigned-binary converter using reverse double
// dabble: 4*DIGITS shift/correct iterations move the decimal value from the
// BCD working register into the binary working register.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset
//   start   : conversion request, only honoured while ready=1
//   bcd_in  : packed BCD operand, digit 0 in bits [3:0]
//   ready   : idle and able to accept start
//   valid   : one-cycle pulse marking bin_out/err as a fresh result
//   bin_out : binary result, held until the next accepted start completes
//   err     : operand contained a digit above 9 (bin_out forced to 0)
// -----------------------------------------------------------------------------
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bin_out,
  output logic                  err
);

  localparam int             W    = 4 * DIGITS;
  localparam int             CW   = $clog2(W + 1);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_bcd_work;
  logic [W-1:0]    r_bin_work;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_valid;
  logic            r_err;
  logic [W-1:0]    r_bin_out;

  logic            w_bad_digit;
  logic [2*W-1:0]  w_shift_cat;
  logic [W-1:0]    w_bcd_sh;
  logic [W-1:0]    w_bin_sh;
  logic [W-1:0]    w_bcd_adj;

  // Flag any nibble of the incoming operand that is not a legal BCD digit.
  always_comb begin
    w_bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (digit_invalid(bcd_in[4*d +: 4])) begin
        w_bad_digit = 1'b1;
      end else begin
        w_bad_digit = w_bad_digit;
      end
    end
  end

  // One-bit right shift of the concatenated {bcd_work, bin_work} pair.
  always_comb begin
    w_shift_cat = {1'b0, r_bcd_work, r_bin_work[W-1:1]};
    w_bcd_sh    = w_shift_cat[2*W-1:W];
    w_bin_sh    = w_shift_cat[W-1:0];
  end

  // Correction of every shifted BCD digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (w_bcd_sh[4*g +: 4]),
      .o_digit (w_bcd_adj[4*g +: 4])
    );
  end

  // Next-state logic of the IDLE/SHIFT/DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_bad_digit ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      // Start during DONE is deliberately not looked at.
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Working registers, iteration counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd_work <= '0;
      r_bin_work <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_bin_out  <= '0;
    end else begin
      // ready/valid are registered copies of the state being entered.
      r_ready <= (w_state_nxt == ST_IDLE);
      r_valid <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bcd_work <= bcd_in;
            r_bin_work <= '0;
            r_cnt      <= '0;
            r_err      <= w_bad_digit;
            if (w_bad_digit) begin
              r_bin_out <= '0;
            end else begin
              r_bin_out <= r_bin_out;
            end
          end else begin
            r_bcd_work <= r_bcd_work;
          end
        end
        ST_SHIFT: begin
          r_bcd_work <= w_bcd_adj;
          r_bin_work <= w_bin_sh;
          r_cnt      <= r_cnt + 1'b1;
          // The last shift leaves the final binary value in w_bin_sh.
          if (r_cnt == LAST) begin
            r_bin_out <= w_bin_sh;
          end else begin
            r_bin_out <= r_bin_out;
          end
        end
        ST_DONE: begin
          r_bin_out <= r_bin_out;
        end
        default: begin
          r_bin_out <= r_bin_out;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign valid   = r_valid;
  assign err     = r_err;
  assign bin_out = r_bin_out;

endmodule
